sample_recorder: RTL and testbench

SAMPLE_RECORDER -- requirements
Module: sample_recorder

---
 rtl/sample_recorder.sv | 183 ++++++++++++++++++
 tb/tb_sample_recorder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// sample_recorder
//   Captures sampler words into a small FIFO and streams them to an SDRAM
//   controller as single-word writes at consecutive word addresses.
//   Each written word is {seq[9:0], sample[21:0]}. seq counts the accepted
//   samples of the current recording, modulo 1024.
//
//   Optional feature: define RECORDER_WRAP_EN to wrap the write address back to
//   0 after ADDR_LAST and keep recording. In the default build the recording
//   ends once the ADDR_LAST word has been accepted.
//
// Parameters
//   FIFO_DEPTH       sample buffer depth (power of two, 2..64)
//   ADDR_LAST        last SDRAM word address of the recording region
//
// Ports
//   clk              system clock, shared with the SDRAM controller and sampler
//   rst              asynchronous active-low reset; release is synchronised to clk
//   start, stop      one-cycle control pulses
//   sample_valid     one-cycle pulse qualifying sample_data
//   sample_data      22-bit sample word
//   cmd_ready        controller can accept a command
//   cmd_enable       write command request; held with address/data until accepted
//   cmd_wr           write strobe (follows cmd_enable)
//   cmd_byte_enable  always 4'b1111
//   cmd_address      word address of the pending write
//   cmd_data_in      write data {seq, sample}
//   busy             recording or draining
//   done             recording finished
//   overflow         sticky: a sample was dropped during this recording
//   words_written    accepted write commands during this recording
module sample_recorder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [22:0] ADDR_LAST  = 23'h7FFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        sample_valid,
  input  logic [21:0] sample_data,
  input  logic        cmd_ready,
  output logic        cmd_enable,
  output logic        cmd_wr,
  output logic [3:0]  cmd_byte_enable,
  output logic [22:0] cmd_address,
  output logic [31:0] cmd_data_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [22:0] words_written
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Reset: asserts asynchronously, releases after two clock edges.
  logic [1:0] rst_sync_reg;
  logic       rst_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_reg <= 2'b00;
    else      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_int = rst_sync_reg[1];

  logic [1:0]  state_reg;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [9:0]    seq_reg;
  logic          load_reg;        // head popped into cmd_data_in, request next cycle
  logic          cmd_enable_reg;
  logic [22:0]   cmd_address_reg;
  logic [31:0]   cmd_data_in_reg;
  logic [22:0]   words_reg;
  logic          overflow_reg;

  logic pending, accept, pop, push_try, push_ok, start_ok, end_hit;
  logic [22:0] addr_next;

  // A command is pending from the pop until the controller accepts it.
  assign pending  = load_reg | cmd_enable_reg;
  assign accept   = cmd_enable_reg & cmd_ready;
  assign pop      = ~pending & (count_reg != '0);
  assign push_try = (state_reg == ST_RUN) & sample_valid;
  assign start_ok = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

`ifdef RECORDER_WRAP_EN
  assign end_hit   = 1'b0;
  assign addr_next = (cmd_address_reg == ADDR_LAST) ? 23'd0 : cmd_address_reg + 23'd1;
`else
  assign end_hit   = accept & (cmd_address_reg == ADDR_LAST);
  assign addr_next = cmd_address_reg + 23'd1;
`endif

  // A full FIFO still takes a sample when the head leaves in the same cycle.
  // When the region end is reached the incoming sample is discarded.
  assign push_ok = push_try & ~end_hit & ((count_reg < FULL_COUNT) | pop);

  // Sample storage without reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {seq_reg, sample_data};
  end

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state_reg       <= ST_IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      seq_reg         <= '0;
      load_reg        <= 1'b0;
      cmd_enable_reg  <= 1'b0;
      cmd_address_reg <= '0;
      cmd_data_in_reg <= '0;
      words_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else if (start_ok) begin
      // No command can be pending in IDLE/DONE, so only the counters clear.
      state_reg       <= ST_RUN;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      seq_reg         <= '0;
      cmd_address_reg <= '0;
      words_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (accept) begin
        cmd_enable_reg  <= 1'b0;
        cmd_address_reg <= addr_next;
        words_reg       <= words_reg + 23'd1;
      end else if (load_reg) begin
        cmd_enable_reg  <= 1'b1;
      end

      load_reg <= pop;
      if (pop) begin
        cmd_data_in_reg <= fifo_mem[rd_ptr_reg];
        rd_ptr_reg      <= rd_ptr_reg + 1'b1;
      end

      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        seq_reg    <= seq_reg + 10'd1;
      end
      if (push_try & ~push_ok) overflow_reg <= 1'b1;

      if (end_hit) begin
        // End of region: whatever is still buffered is lost.
        state_reg  <= ST_DONE;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        if (count_reg != '0) overflow_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
        case (state_reg)
          ST_RUN:   if (stop) state_reg <= ST_DRAIN;
          ST_DRAIN: if ((count_reg == '0) && !pending) state_reg <= ST_DONE;
          default:  ;
        endcase
      end
    end
  end

  assign cmd_enable      = cmd_enable_reg;
  assign cmd_wr          = cmd_enable_reg;
  assign cmd_byte_enable = 4'b1111;
  assign cmd_address     = cmd_address_reg;
  assign cmd_data_in     = cmd_data_in_reg;
  assign busy            = (state_reg == ST_RUN) | (state_reg == ST_DRAIN);
  assign done            = (state_reg == ST_DONE);
  assign overflow        = overflow_reg;
  assign words_written   = words_reg;

endmodule

// File: tb/tb_sample_recorder.sv
module tb_sample_recorder;

  localparam int          DEPTH = 8;
  localparam logic [22:0] LAST  = 23'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_valid = 1'b0;
  logic [21:0] sample_data = '0;
  logic        cmd_ready = 1'b0;
  logic        cmd_enable, cmd_wr, busy, done, overflow;
  logic [3:0]  cmd_byte_enable;
  logic [22:0] cmd_address, words_written;
  logic [31:0] cmd_data_in;

  sample_recorder #(.FIFO_DEPTH(DEPTH), .ADDR_LAST(LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .sample_valid(sample_valid), .sample_data(sample_data), .cmd_ready(cmd_ready),
    .cmd_enable(cmd_enable), .cmd_wr(cmd_wr), .cmd_byte_enable(cmd_byte_enable),
    .cmd_address(cmd_address), .cmd_data_in(cmd_data_in), .busy(busy), .done(done),
    .overflow(overflow), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [54:0] exp_q[$];   // {address, data} expected, in write order
  logic [54:0] obs_q[$];   // {address, data} observed by the monitor

  // ---------------- reference model (transaction level) ----------------
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
  mstate_t     m_state = M_IDLE;
  logic [31:0] m_fifo[$];
  int          m_slot = 0;      // 0 none, 1 popped (request next cycle), 2 offered
  logic [31:0] m_data = '0;
  logic [22:0] m_addr = '0;
  logic [22:0] m_words = '0;
  logic [9:0]  m_seq = '0;
  bit          m_ovf = 1'b0;

  always @(posedge clk) begin : model
    bit acc, fin, do_pop, try_push, drained;
    if (!rst) begin
      m_state = M_IDLE; m_fifo.delete(); m_slot = 0; m_data = '0;
      m_addr = '0; m_words = '0; m_seq = '0; m_ovf = 1'b0;
    end else begin
      acc      = (m_slot == 2) && cmd_ready;
      fin      = 1'b0;
`ifndef RECORDER_WRAP_EN
      fin      = acc && (m_addr == LAST);
`endif
      do_pop   = (m_slot == 0) && (m_fifo.size() > 0);
      try_push = (m_state == M_RUN) && sample_valid;
      drained  = (m_slot == 0) && (m_fifo.size() == 0);
      if ((m_state == M_IDLE || m_state == M_DONE) && start) begin
        m_state = M_RUN; m_fifo.delete(); m_addr = '0; m_words = '0;
        m_seq = '0; m_ovf = 1'b0;
      end else begin
        if (acc) begin
          exp_q.push_back({m_addr, m_data});
`ifdef RECORDER_WRAP_EN
          m_addr = (m_addr == LAST) ? 23'd0 : m_addr + 23'd1;
`else
          m_addr = m_addr + 23'd1;
`endif
          m_words = m_words + 23'd1;
          m_slot = 0;
        end else if (m_slot == 1) begin
          m_slot = 2;
        end
        if (do_pop) begin
          m_data = m_fifo.pop_front();
          m_slot = 1;
        end
        if (try_push) begin
          if (!fin && m_fifo.size() < DEPTH) begin
            m_fifo.push_back({m_seq, sample_data});
            m_seq = m_seq + 10'd1;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (fin) begin
          if (m_fifo.size() > 0) m_ovf = 1'b1;
          m_fifo.delete();
          m_state = M_DONE;
        end else if (m_state == M_RUN && stop) begin
          m_state = M_DRAIN;
        end else if (m_state == M_DRAIN && drained) begin
          m_state = M_DONE;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  // A request seen at a falling edge is accepted at the next rising edge;
  // it is compared at the following falling edge, once the model has logged it.
  logic [54:0] cap = '0;
  bit          cap_valid = 1'b0;

  always @(negedge clk) begin : monitor
    logic [54:0] e;
    if (cap_valid) begin
      cap_valid = 1'b0;
      n_cmp++;
      $display("write addr=%0d data=%08h", cap[54:32], cap[31:0]);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%0d data=%08h, required none", cap[54:32], cap[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (e !== cap) begin
          n_fail++;
          $display("FAIL write_compare: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   cap[54:32], cap[31:0], e[54:32], e[31:0]);
        end
      end
      obs_q.push_back(cap);
    end
    if (rst && cmd_enable && cmd_ready) begin
      cap = {cmd_address, cmd_data_in};
      cap_valid = 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_sample(input logic [21:0] d);
    sample_valid = 1'b1; sample_data = d; tick(); sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      tick();
      i++;
    end
    check({name, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(m_state == M_RUN || m_state == M_DRAIN));
    check({tag, "_done"}, 32'(done), 32'(m_state == M_DONE));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_words"}, 32'(words_written), 32'(m_words));
    check({tag, "_enable"}, 32'(cmd_enable), 32'(m_slot == 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] t1_data [3];
  logic [9:0]  s_prev, s_cur;
  bit          contig;
  int          nobs;

  initial begin
    t1_data[0] = 32'h00000001;
    t1_data[1] = 32'h00400002;
    t1_data[2] = 32'h00800003;

    // Reset state
    #1 rst = 1'b0;
    idle(3);
    check("rst_enable", 32'(cmd_enable), 0);
    check("rst_wr", 32'(cmd_wr), 0);
    check("rst_address", 32'(cmd_address), 0);
    check("rst_data", cmd_data_in, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_words", 32'(words_written), 0);
    check("byte_enable", 32'(cmd_byte_enable), 32'hF);
    rst = 1'b1;
    idle(4);

    // Three samples with the controller always ready; first-write latency
    obs_q.delete();
    cmd_ready = 1'b1;
    pulse_start();
    idle(2);
    pulse_sample(22'h1);
    check("lat_edge_n", 32'(cmd_enable), 0);
    tick();
    check("lat_edge_n1", 32'(cmd_enable), 0);
    tick();
    check("lat_edge_n2", 32'(cmd_enable), 1);
    idle(2);
    pulse_sample(22'h2);
    idle(4);
    pulse_sample(22'h3);
    idle(6);
    check("t1_words", 32'(words_written), 3);
    check("t1_nwrites", 32'(obs_q.size()), 3);
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      check($sformatf("t1_addr%0d", i), 32'(obs_q[i][54:32]), 32'(i));
      check($sformatf("t1_data%0d", i), obs_q[i][31:0], t1_data[i]);
    end
    check_status("t1");
    pulse_stop();
    wait_done("t1", 20);

    // Stalled controller: overflow, then contiguous drain
    obs_q.delete();
    cmd_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_data = 22'($urandom);
      tick();
    end
    sample_valid = 1'b0;
    idle(5);
    check("t2_overflow", 32'(overflow), 1);
    check("t2_no_write_stalled", 32'(obs_q.size()), 0);
    check_status("t2a");
    cmd_ready = 1'b1;
    idle(45);
    nobs = obs_q.size();
    check("t2_count_8_or_9", 32'(nobs == 8 || nobs == 9), 1);
    contig = 1'b1;
    for (int i = 1; i < nobs; i++) begin
      s_prev = obs_q[i-1][31:22];
      s_cur  = obs_q[i][31:22];
      if (s_cur != s_prev + 10'd1) contig = 1'b0;
    end
    check("t2_seq_contig", 32'(contig), 1);
    check_status("t2b");
    pulse_stop();
    wait_done("t2", 20);

    // Drain after stop with a toggling ready
    obs_q.delete();
    cmd_ready = 1'b0;
    pulse_start();
    pulse_sample(22'($urandom));
    pulse_sample(22'($urandom));
    idle(3);
    pulse_stop();
    check("t3_busy_drain", 32'(busy), 1);
    for (int i = 0; i < 30; i++) begin
      cmd_ready = i[0];
      tick();
    end
    check("t3_done", 32'(done), 1);
    check("t3_busy", 32'(busy), 0);
    check("t3_nwrites", 32'(obs_q.size()), 2);
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) pulse_sample(22'($urandom));
    idle(6);
    check("t3_words_after", 32'(words_written), 2);
    check("t3_overflow", 32'(overflow), 0);
    check_status("t3");

    // start while running is ignored
    obs_q.delete();
    cmd_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) pulse_sample(22'($urandom));
    idle(2);
    pulse_start();
    idle(2);
    check("t4_busy", 32'(busy), 1);
    cmd_ready = 1'b1;
    idle(20);
    check("t4_words", 32'(words_written), 3);
    check("t4_last_addr", (obs_q.size() > 0) ? 32'(obs_q[obs_q.size()-1][54:32]) : 32'hFFFF_FFFF, 2);
    check_status("t4");
    pulse_stop();
    wait_done("t4", 20);

    // Randomised recordings
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 90; c++) begin
        start        = ($urandom_range(0, 30) == 0);
        stop         = ($urandom_range(0, 60) == 0);
        sample_valid = ($urandom_range(0, 2) != 0);
        sample_data  = 22'($urandom);
        cmd_ready    = ($urandom_range(0, 3) != 0);
        tick();
      end
      start = 1'b0; sample_valid = 1'b0; cmd_ready = 1'b1;
      pulse_stop();
      if (!done) wait_done($sformatf("rnd%0d", r), 200);
      check_status($sformatf("rnd%0d", r));
      pulse_start();
    end
    pulse_stop();
    wait_done("rnd_end", 200);

    // End of the recording region
    obs_q.delete();
    cmd_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < int'(LAST) + 6; i++) begin
      pulse_sample(22'(i + 1));
      idle(3);
    end
    idle(4);
    nobs = obs_q.size();
`ifdef RECORDER_WRAP_EN
    check("t6_busy", 32'(busy), 1);
    check("t6_words", 32'(words_written), 32'(int'(LAST) + 6));
    check("t6_last_addr", (nobs > 0) ? 32'(obs_q[nobs-1][54:32]) : 32'hFFFF_FFFF, 32'((int'(LAST) + 5) % (int'(LAST) + 1)));
    check_status("t6");
    pulse_stop();
    wait_done("t6", 20);
`else
    check("t6_done", 32'(done), 1);
    check("t6_words", 32'(words_written), 32'(int'(LAST) + 1));
    check("t6_last_addr", (nobs > 0) ? 32'(obs_q[nobs-1][54:32]) : 32'hFFFF_FFFF, 32'(LAST));
    check_status("t6");
`endif

    // Reset while a command is pending
    obs_q.delete();
    cmd_ready = 1'b0;
    pulse_start();
    pulse_sample(22'h5);
    idle(3);
    check("t7_enable_before", 32'(cmd_enable), 1);
    #2 rst = 1'b0;
    #1;
    check("t7_enable_async", 32'(cmd_enable), 0);
    check("t7_wr_async", 32'(cmd_wr), 0);
    check("t7_busy_async", 32'(busy), 0);
    check("t7_words_async", 32'(words_written), 0);
    idle(3);
    rst = 1'b1;
    idle(4);
    cmd_ready = 1'b1;
    pulse_start();
    pulse_sample(22'h2A);
    idle(6);
    check("t7_nwrites", 32'(obs_q.size()), 1);
    check("t7_addr", (obs_q.size() > 0) ? 32'(obs_q[0][54:32]) : 32'hFFFF_FFFF, 0);
    check("t7_data", (obs_q.size() > 0) ? obs_q[0][31:0] : 32'hFFFF_FFFF, 32'h0000002A);
    check_status("t7");
    pulse_stop();
    wait_done("t7", 20);

    idle(4);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
